// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: Moore-decoded datapath selects/strobes,
// memory-ready handshake with timeout, retired-instruction counter.
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcEn,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic [1:0]       pcSource,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regDst,
  output logic             memToReg,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [3:0]       state,
  output logic             memErr,
  output logic             illegalOp,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RCOMP  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam int WW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] WMAX = WW'(MEM_WAIT_MAX);

  state_t        cur, nxt;
  logic [WW-1:0] waitCnt;
  logic          waitSt;
  logic          timeout;
  logic          retireEv;
  logic          illegal;

  assign waitSt  = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
  assign timeout = waitSt && !memReady && (MEM_WAIT_MAX != 0) &&
                   (waitCnt == WMAX);

  assign retireEv = (cur == MEMWB) || (cur == RCOMP) || (cur == BRANCH) ||
                    (cur == JUMP) || (cur == ADDIWB) ||
                    ((cur == MEMWR) && memReady);

  always_comb begin
    nxt     = cur;
    illegal = 1'b0;
    unique case (cur)
      FETCH:  nxt = memReady ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          opcode == 6'b000000: nxt = EXEC;
          opcode == 6'b100011,
          opcode == 6'b101011: nxt = MEMADR;
          opcode == 6'b000100: nxt = BRANCH;
          opcode == 6'b000010: nxt = JUMP;
          opcode == 6'b001000: nxt = ADDIEX;
          default: begin
            nxt     = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: nxt = (opcode == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:  nxt = memReady ? MEMWB : MEMRD;
      MEMWR:  nxt = memReady ? FETCH : MEMWR;
      EXEC:   nxt = RCOMP;
      ADDIEX: nxt = ADDIWB;
      MEMWB,
      RCOMP,
      BRANCH,
      JUMP,
      ADDIWB: nxt = FETCH;
      default: nxt = FETCH;
    endcase
    // memReady wins over the abort on the limit cycle
    if (timeout) nxt = FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= FETCH;
      waitCnt   <= '0;
      retired   <= '0;
      memErr    <= 1'b0;
      illegalOp <= 1'b0;
    end else begin
      cur       <= nxt;
      memErr    <= timeout;
      illegalOp <= illegal && (cur == DECODE);
      if (nxt != cur || timeout)
        waitCnt <= '0;
      else if (waitSt && !memReady && waitCnt != WMAX)
        waitCnt <= waitCnt + 1'b1;
      if (retireEv)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSource    = 2'b00;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    unique case (cur)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE: aluSrcB = 2'b11;
      MEMADR,
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      MEMWR: begin
        iorD     = 1'b1;
        memWrite = memReady;
      end
      MEMWB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      RCOMP: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
      end
      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      ADDIWB: regWrite = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      pcSource    = 2'b00;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regDst      = 1'b0;
      memToReg    = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
    end
  end

  assign pcEn  = pcWrite | (pcWriteCond & zero);
  assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction walks, wait states,
// memory timeout, illegal opcode and mid-instruction reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        memReady;
  logic        pcEn, pcWrite, pcWriteCond, iorD, memRead, memWrite;
  logic        irWrite, regDst, memToReg, regWrite, aluSrcA;
  logic [1:0]  pcSource, aluSrcB, aluOp;
  logic [3:0]  state;
  logic        memErr, illegalOp;
  logic [31:0] retired;

  int nChecks = 0;
  int nErrs   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .memReady(memReady), .pcEn(pcEn), .pcWrite(pcWrite),
    .pcWriteCond(pcWriteCond), .pcSource(pcSource), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .state(state), .memErr(memErr), .illegalOp(illegalOp),
    .retired(retired)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; zero = 1'b0; memReady = 1'b1;
    step(); step();
    chk("rst.state", 32'(state), 0);
    chk("rst.retired", retired, 0);
    chk("rst.memRead", 32'(memRead), 0);
    chk("rst.pcWrite", 32'(pcWrite), 0);
    chk("rst.irWrite", 32'(irWrite), 0);
    chk("rst.aluSrcB", 32'(aluSrcB), 0);
    chk("rst.memErr", 32'(memErr), 0);
    rst = 1'b0;
    #1;
    chk("f.memRead", 32'(memRead), 1);
    chk("f.aluSrcB", 32'(aluSrcB), 1);
    chk("f.irWrite", 32'(irWrite), 1);

    // R-type
    step(); chk("r.s1", 32'(state), 1);
    chk("r.aluSrcB", 32'(aluSrcB), 3);
    step(); chk("r.s6", 32'(state), 6);
    chk("r.aluOp", 32'(aluOp), 2);
    chk("r.regWrite6", 32'(regWrite), 0);
    step(); chk("r.s7", 32'(state), 7);
    chk("r.regWrite", 32'(regWrite), 1);
    chk("r.regDst", 32'(regDst), 1);
    step(); chk("r.s0", 32'(state), 0);
    chk("r.retired", retired, 1);

    // lw
    opcode = 6'h23;
    step(); chk("lw.s1", 32'(state), 1);
    step(); chk("lw.s2", 32'(state), 2);
    chk("lw.aluSrcB", 32'(aluSrcB), 2);
    step(); chk("lw.s3", 32'(state), 3);
    chk("lw.iorD", 32'(iorD), 1);
    chk("lw.memRead", 32'(memRead), 1);
    step(); chk("lw.s4", 32'(state), 4);
    chk("lw.memToReg", 32'(memToReg), 1);
    chk("lw.regWrite", 32'(regWrite), 1);
    step(); chk("lw.s0", 32'(state), 0);
    chk("lw.retired", retired, 2);

    // sw
    opcode = 6'h2b;
    step(); step(); chk("sw.s2", 32'(state), 2);
    step(); chk("sw.s5", 32'(state), 5);
    chk("sw.memWrite", 32'(memWrite), 1);
    step(); chk("sw.s0", 32'(state), 0);
    chk("sw.retired", retired, 3);

    // beq taken / not taken
    opcode = 6'h04; zero = 1'b1;
    step(); step(); chk("beq1.s8", 32'(state), 8);
    chk("beq1.pcEn", 32'(pcEn), 1);
    chk("beq1.pcSource", 32'(pcSource), 1);
    chk("beq1.aluOp", 32'(aluOp), 1);
    step(); chk("beq1.retired", retired, 4);
    zero = 1'b0;
    step(); step(); chk("beq0.s8", 32'(state), 8);
    chk("beq0.pcEn", 32'(pcEn), 0);
    step(); chk("beq0.s0", 32'(state), 0);
    chk("beq0.retired", retired, 5);

    // jump
    opcode = 6'h02;
    step(); step(); chk("j.s9", 32'(state), 9);
    chk("j.pcEn", 32'(pcEn), 1);
    chk("j.pcSource", 32'(pcSource), 2);
    step(); chk("j.retired", retired, 6);

    // addi
    opcode = 6'h08;
    step(); step(); chk("addi.s10", 32'(state), 10);
    chk("addi.aluSrcA", 32'(aluSrcA), 1);
    step(); chk("addi.s11", 32'(state), 11);
    chk("addi.regWrite", 32'(regWrite), 1);
    chk("addi.regDst", 32'(regDst), 0);
    step(); chk("addi.retired", retired, 7);

    // fetch with 3 wait cycles
    memReady = 1'b0;
    #1;
    chk("fw.irWrite0", 32'(irWrite), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("fw.state", 32'(state), 0);
      chk("fw.pcWrite", 32'(pcWrite), 0);
    end
    step();
    memReady = 1'b1;
    #1;
    chk("fw.s0last", 32'(state), 0);
    chk("fw.irWrite", 32'(irWrite), 1);
    chk("fw.pcWrite1", 32'(pcWrite), 1);
    step(); chk("fw.s1", 32'(state), 1);
    step(); step(); step();
    chk("fw.retired", retired, 8);

    // lw timeout in MEMRD
    opcode = 6'h23;
    step(); step(); step();
    chk("to.s3", 32'(state), 3);
    memReady = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to.hold", 32'(state), 3);
      chk("to.regWrite", 32'(regWrite), 0);
      chk("to.noErr", 32'(memErr), 0);
    end
    step();
    chk("to.s0", 32'(state), 0);
    chk("to.memErr", 32'(memErr), 1);
    chk("to.retired", retired, 8);
    memReady = 1'b1;
    step();
    chk("to.errPulse", 32'(memErr), 0);
    chk("to.s1", 32'(state), 1);

    // memReady on the limit cycle completes normally
    step(); step();
    chk("lim.s3", 32'(state), 3);
    memReady = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("lim.hold", 32'(state), 3);
    memReady = 1'b1;
    step();
    chk("lim.s4", 32'(state), 4);
    chk("lim.memErr", 32'(memErr), 0);
    step();
    chk("lim.retired", retired, 9);

    // illegal opcode
    opcode = 6'h3f;
    step(); chk("ill.s1", 32'(state), 1);
    step(); chk("ill.s0", 32'(state), 0);
    chk("ill.pulse", 32'(illegalOp), 1);
    chk("ill.retired", retired, 9);
    opcode = 6'h2b;
    step(); chk("ill.pulseEnd", 32'(illegalOp), 0);

    // reset while in MEMWR
    step(); step(); chk("rs.s5", 32'(state), 5);
    chk("rs.memWrite1", 32'(memWrite), 1);
    rst = 1'b1;
    #1;
    chk("rs.memWrite", 32'(memWrite), 0);
    chk("rs.iorD", 32'(iorD), 0);
    step();
    chk("rs.s0", 32'(state), 0);
    chk("rs.retired", retired, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
    $finish;
  end

endmodule
